fork_scheduler: RTL and testbench

- Central fork controller for the threadbrain multicore array.
- Accepts FORK requests from running cores, arbitrates round-robin between them, and allocates the lowest-index idle core.
- Owns the per-core enable mask and start-PC registers that drive core launch.
- Tracks core halts so freed cores can be reused.

---
 rtl/fork_scheduler_pkg.sv | 19 +
 rtl/fork_scheduler_rr_pick.sv | 41 ++++
 rtl/fork_scheduler.sv | 165 ++++++++++++++++
 tb/tb_fork_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fork_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// threadbrain_pkg
// Shared definitions for the threadbrain fork controller slice.
//   - fork_state_e : fork FSM state encoding (IDLE / ALLOC / ACK)
//   - OP_FORK      : FORK opcode value seen by the cores
//   - PC_W_DEFAULT : default width of a start PC
// -----------------------------------------------------------------------------
package threadbrain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_ACK   = 2'd2
    } fork_state_e;

    localparam logic [3:0]  OP_FORK      = 4'h6;
    localparam int unsigned PC_W_DEFAULT = 16;

endpackage

// File: rtl/fork_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin first-set-bit finder: returns the first set bit of req at or
// after ptr, wrapping modulo N. With ptr tied to zero it is a plain
// lowest-set-bit finder.
// Ports:
//   req   [N-1:0]  candidate mask
//   ptr   [IW-1:0] starting index of the search
//   grant [N-1:0]  one-hot winner (zero when req is empty)
//   idx   [IW-1:0] index of the winner (zero when req is empty)
//   valid          at least one bit of req was set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fork_scheduler.sv
// -----------------------------------------------------------------------------
// fork_scheduler
// Central fork controller for the threadbrain multicore array. Arbitrates
// FORK requests round-robin among enabled cores, allocates the lowest-index
// idle core, owns the core enable mask and start-PC registers, and frees
// cores on halt.
// Optional feature macro: FORK_FAIL_EN (refuse a fork with fork_nack when no
// core is free instead of stalling in ALLOC).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   fork_req     per-core level request, held until ack/nack
//   fork_pc      per-core requested child PC (slice i = core i)
//   core_halt    per-core halt pulse
//   fork_ack     one-cycle grant pulse to the requester
//   fork_nack    one-cycle refusal pulse (0 unless FORK_FAIL_EN)
//   core_en      registered enable mask
//   core_start   registered start PC per core
//   core_launch  one-cycle launch pulse for the allocated core
//   busy         FSM not IDLE
// -----------------------------------------------------------------------------
module fork_scheduler
    import threadbrain_pkg::*;
#(
    parameter int unsigned     NCORES  = 4,
    parameter int unsigned     PC_W    = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] BOOT_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCORES-1:0]      fork_req,
    input  logic [NCORES*PC_W-1:0] fork_pc,
    input  logic [NCORES-1:0]      core_halt,
    output logic [NCORES-1:0]      fork_ack,
    output logic [NCORES-1:0]      fork_nack,
    output logic [NCORES-1:0]      core_en,
    output logic [NCORES*PC_W-1:0] core_start,
    output logic [NCORES-1:0]      core_launch,
    output logic                   busy
);

    localparam int unsigned IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ALLOC = ST_ALLOC;
    localparam logic [1:0] S_ACK   = ST_ACK;

    logic [1:0]                   r_state;
    logic [IW-1:0]                r_ptr;
    logic [IW-1:0]                r_win_idx;
    logic [NCORES-1:0]            r_win_oh;
    logic [PC_W-1:0]              r_pc;
    logic [NCORES-1:0]            r_core_en;
    logic [NCORES-1:0][PC_W-1:0]  r_start;
    logic [NCORES-1:0]            r_ack;
    logic [NCORES-1:0]            r_launch;
`ifdef FORK_FAIL_EN
    logic [NCORES-1:0]            r_nack;
`endif

    logic [NCORES-1:0][PC_W-1:0]  w_pc_arr;
    logic [NCORES-1:0]            w_elig;
    logic [NCORES-1:0]            w_win_oh;
    logic [IW-1:0]                w_win_idx;
    logic                         w_win_vld;
    logic [NCORES-1:0]            w_free_oh;
    logic [IW-1:0]                w_free_idx;
    logic                         w_free_vld;
    logic [NCORES-1:0]            w_alloc;
    logic [NCORES-1:0]            w_en_next;
    logic [IW-1:0]                w_ptr_inc;

    assign w_pc_arr = fork_pc;
    // Requests from disabled cores are never eligible.
    assign w_elig   = fork_req & r_core_en;

    rr_pick #(.N(NCORES)) u_req_pick (
        .req   (w_elig),
        .ptr   (r_ptr),
        .grant (w_win_oh),
        .idx   (w_win_idx),
        .valid (w_win_vld)
    );

    // Lowest-index free core: same finder with the pointer pinned to 0.
    // Uses the registered mask, so a core halted this cycle is only
    // allocatable from the next cycle.
    rr_pick #(.N(NCORES)) u_free_pick (
        .req   (~r_core_en),
        .ptr   ('0),
        .grant (w_free_oh),
        .idx   (w_free_idx),
        .valid (w_free_vld)
    );

    assign w_ptr_inc = (r_win_idx == IW'(NCORES - 1)) ? '0 : r_win_idx + IW'(1);
    assign w_alloc   = ((r_state == S_ALLOC) && w_free_vld) ? w_free_oh : '0;
    // The allocated core is disabled before the edge, so a halt pulse on it
    // is a no-op and the set term never conflicts with the clear term.
    assign w_en_next = (r_core_en & ~core_halt) | w_alloc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_win_idx  <= '0;
            r_win_oh   <= '0;
            r_pc       <= '0;
            r_core_en  <= NCORES'(1);
            r_start    <= '0;
            r_start[0] <= BOOT_PC;
            r_ack      <= '0;
            r_launch   <= '0;
`ifdef FORK_FAIL_EN
            r_nack     <= '0;
`endif
        end else begin
            r_ack     <= '0;
            r_launch  <= '0;
`ifdef FORK_FAIL_EN
            r_nack    <= '0;
`endif
            r_core_en <= w_en_next;
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_win_idx <= w_win_idx;
                        r_win_oh  <= w_win_oh;
                        r_pc      <= w_pc_arr[w_win_idx];
                        r_state   <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (w_free_vld) begin
                        r_start[w_free_idx] <= r_pc;
                        r_launch            <= w_free_oh;
                        r_ack               <= r_win_oh;
                        r_ptr               <= w_ptr_inc;
                        r_state             <= S_ACK;
                    end
`ifdef FORK_FAIL_EN
                    else begin
                        r_nack  <= r_win_oh;
                        r_ptr   <= w_ptr_inc;
                        r_state <= S_ACK;
                    end
`endif
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fork_ack    = r_ack;
    assign core_launch = r_launch;
    assign core_en     = r_core_en;
    assign core_start  = r_start;
    assign busy        = (r_state != S_IDLE);
`ifdef FORK_FAIL_EN
    assign fork_nack   = r_nack;
`else
    assign fork_nack   = '0;
`endif

endmodule

// File: tb/tb_fork_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fork_scheduler
// Directed scenarios with literal expectations, then randomized requests and
// halts, all compared every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_fork_scheduler;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [3:0][15:0] pc_arr;
    logic [3:0]       halt;
    logic [3:0]       fork_ack, fork_nack, core_en, core_launch;
    logic [63:0]      core_start;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fork_scheduler #(
        .NCORES  (4),
        .PC_W    (16),
        .BOOT_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fork_req    (req),
        .fork_pc     (pc_arr),
        .core_halt   (halt),
        .fork_ack    (fork_ack),
        .fork_nack   (fork_nack),
        .core_en     (core_en),
        .core_start  (core_start),
        .core_launch (core_launch),
        .busy        (busy)
    );

    // ---------------- behavioural model ----------------
    // m_phase: 0 = no fork in flight, 1 = winner chosen and waiting for a
    // free core, 2 = the cycle in which ack/nack is visible.
    logic [3:0]       m_en;
    logic [3:0][15:0] m_start;
    logic [3:0]       m_ack, m_nack, m_launch;
    int               m_ptr, m_phase, m_w;
    logic [15:0]      m_pc;
    logic [3:0]       ghost;

    function automatic int first_from(logic [3:0] m, int start);
        for (int k = 0; k < 4; k++) begin
            int j = (start + k) % 4;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_en     = 4'b0001;
        m_start  = '0;
        m_ack    = '0;
        m_nack   = '0;
        m_launch = '0;
        m_ptr    = 0;
        m_phase  = 0;
        m_w      = 0;
        m_pc     = '0;
    endtask

    task automatic model_step();
        logic [3:0] en_nx;
        int w, f;
        if (rst) begin
            model_reset();
            return;
        end
        m_ack    = '0;
        m_nack   = '0;
        m_launch = '0;
        en_nx    = m_en & ~halt;
        if (m_phase == 0) begin
            w = first_from(req & m_en, m_ptr);
            if (w >= 0) begin
                m_w     = w;
                m_pc    = pc_arr[w];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            f = first_from(~m_en, 0);
            if (f >= 0) begin
                en_nx[f]    = 1'b1;
                m_start[f]  = m_pc;
                m_launch[f] = 1'b1;
                m_ack[m_w]  = 1'b1;
                m_ptr       = (m_w + 1) % 4;
                m_phase     = 2;
            end
`ifdef FORK_FAIL_EN
            else begin
                m_nack[m_w] = 1'b1;
                m_ptr       = (m_w + 1) % 4;
                m_phase     = 2;
            end
`endif
        end else begin
            m_phase = 0;
        end
        m_en = en_nx;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("ack",    64'(fork_ack),    64'(m_ack));
        chk("nack",   64'(fork_nack),   64'(m_nack));
        chk("launch", 64'(core_launch), 64'(m_launch));
        chk("en",     64'(core_en),     64'(m_en));
        chk("start",  core_start,       m_start);
        chk("busy",   64'(busy),        64'(m_phase != 0));
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic gen_stim();
        halt = '0;
        for (int i = 0; i < 4; i++) begin
            if (ghost[i]) begin
                req[i]   = 1'b0;
                ghost[i] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (m_ack[i] || m_nack[i])) begin
                req[i] = 1'b0;
            end else if (!req[i]) begin
                if (m_en[i] && $urandom_range(0, 5) == 0) begin
                    req[i]    = 1'b1;
                    pc_arr[i] = 16'($urandom);
                end else if (!m_en[i] && $urandom_range(0, 11) == 0) begin
                    req[i]    = 1'b1;
                    ghost[i]  = 1'b1;
                    pc_arr[i] = 16'($urandom);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (m_en[i] && $countones(m_en & ~halt) > 1 &&
                (!req[i] || (m_phase != 0 && m_w == i)) &&
                $urandom_range(0, 9) == 0)
                halt[i] = 1'b1;
            else if (!m_en[i] && $urandom_range(0, 19) == 0)
                halt[i] = 1'b1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        halt   = '0;
        pc_arr = '0;
        ghost  = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_en",    64'(core_en), 64'h1);
        chk("rst_start", core_start,   64'h0);
        chk("rst_busy",  64'(busy),    64'h0);

        // Single fork from core 0 launches core 1 two cycles later.
        req[0] = 1'b1; pc_arr[0] = 16'h0123;
        tick();
        chk("tp1_busy", 64'(busy), 64'h1);
        tick();
        chk("tp1_ack",    64'(fork_ack),    64'h1);
        chk("tp1_launch", 64'(core_launch), 64'h2);
        chk("tp1_en",     64'(core_en),     64'h3);
        chk("tp1_start1", 64'(core_start[31:16]), 64'h0123);
        req[0] = 1'b0;
        tick();

        // Second fork from core 0 launches core 2; pointer now at 1.
        req[0] = 1'b1; pc_arr[0] = 16'h0456;
        tick(); tick();
        chk("tp2a_launch", 64'(core_launch), 64'h4);
        req[0] = 1'b0;
        tick();

        // Cores 0 and 2 together: 2 wins from pointer 1 and gets core 3.
        req[0] = 1'b1; pc_arr[0] = 16'h0AAA;
        req[2] = 1'b1; pc_arr[2] = 16'h0789;
        tick(); tick();
        chk("tp2_ack",    64'(fork_ack),    64'h4);
        chk("tp2_launch", 64'(core_launch), 64'h8);
        chk("tp2_en",     64'(core_en),     64'hF);
        chk("tp2_start3", 64'(core_start[63:48]), 64'h0789);
        req[2] = 1'b0;
        tick(); tick(); tick();
`ifdef FORK_FAIL_EN
        chk("tp3_nack", 64'(fork_nack), 64'h1);
        chk("tp3_en",   64'(core_en),   64'hF);
        req[0] = 1'b0;
        tick();
`else
        chk("tp3_stall_busy", 64'(busy),     64'h1);
        chk("tp3_stall_ack",  64'(fork_ack), 64'h0);
        halt[3] = 1'b1;
        tick();
        halt = '0;
        chk("tp3_halt_en", 64'(core_en), 64'h7);
        tick();
        chk("tp3_ack",    64'(fork_ack),    64'h1);
        chk("tp3_launch", 64'(core_launch), 64'h8);
        chk("tp3_start3", 64'(core_start[63:48]), 64'h0AAA);
        req[0] = 1'b0;
        tick();
`endif

        // Halt of core 2 during ALLOC with mask 0111: core 3 allocated.
        halt[3] = 1'b1;
        tick();
        halt = '0;
        req[1] = 1'b1; pc_arr[1] = 16'h0BBB;
        tick();
        halt[2] = 1'b1;
        tick();
        chk("tp4_en",     64'(core_en),     64'hB);
        chk("tp4_launch", 64'(core_launch), 64'h8);
        chk("tp4_ack",    64'(fork_ack),    64'h2);
        halt = '0;
        req[1] = 1'b0;
        tick();

        // Asynchronous reset while a fork sits in ALLOC.
        req[0] = 1'b1; pc_arr[0] = 16'h0CCC;
        tick();
        rst = 1'b1;
        #1;
        chk("tp5_en",     64'(core_en),     64'h1);
        chk("tp5_busy",   64'(busy),        64'h0);
        chk("tp5_ack",    64'(fork_ack),    64'h0);
        chk("tp5_launch", 64'(core_launch), 64'h0);
        model_reset();
        req = '0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("tp5_noack", 64'(fork_ack), 64'h0);

        // Request from disabled core 3 is ignored.
        req[3] = 1'b1; pc_arr[3] = 16'h0DDD;
        tick();
        chk("tp6_busy_a", 64'(busy), 64'h0);
        tick();
        chk("tp6_busy_b", 64'(busy), 64'h0);
        req[3] = 1'b0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            gen_stim();
            tick();
        end
        req  = '0;
        halt = '0;
        tick(); tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
